// File: rtl/fpu_arb_pkg.sv
// Shared types and helpers for the FPU issue arbiter.
//   FLAG_WIDTH : FPU exception flag width
//   ID_W       : requester id width (sized for the largest supported NUM_REQ)
//   fpu_tag_t  : {valid, id} entry travelling alongside an op in the FPU
package fpu_arb_pkg;
  localparam int FLAG_WIDTH = 5;
  localparam int MAX_REQ    = 16;
  localparam int ID_W       = 4;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } fpu_tag_t;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) idx = idx | ID_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/fpu_issue_arbiter_if.sv
// Requester + FPU bus of the issue arbiter.
//   slave  : arbiter side (takes requests and FPU results, drives grants,
//            FPU issue and responses)
//   master : requester/FPU side
interface fpu_issue_arbiter_if
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
);
  logic [NUM_REQ-1:0]            I_Req;
  logic [NUM_REQ*OP_WIDTH-1:0]   I_Op;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_A;
  logic [NUM_REQ*DATA_WIDTH-1:0] I_B;
  logic                          I_Hold;
  logic [NUM_REQ-1:0]            O_Gnt;
  logic                          O_Fpu_Valid;
  logic [OP_WIDTH-1:0]           O_Fpu_Op;
  logic [DATA_WIDTH-1:0]         O_Fpu_A;
  logic [DATA_WIDTH-1:0]         O_Fpu_B;
  logic [DATA_WIDTH-1:0]         I_Fpu_Result;
  logic [FLAG_WIDTH-1:0]         I_Fpu_Flags;
  logic [NUM_REQ-1:0]            O_Rsp_Valid;
  logic [DATA_WIDTH-1:0]         O_Rsp_Data;
  logic [FLAG_WIDTH-1:0]         O_Rsp_Flags;
  logic                          O_Idle;

  modport slave (
    input  I_Req, I_Op, I_A, I_B, I_Hold, I_Fpu_Result, I_Fpu_Flags,
    output O_Gnt, O_Fpu_Valid, O_Fpu_Op, O_Fpu_A, O_Fpu_B,
           O_Rsp_Valid, O_Rsp_Data, O_Rsp_Flags, O_Idle
  );
  modport master (
    output I_Req, I_Op, I_A, I_B, I_Hold, I_Fpu_Result, I_Fpu_Flags,
    input  O_Gnt, O_Fpu_Valid, O_Fpu_Op, O_Fpu_A, O_Fpu_B,
           O_Rsp_Valid, O_Rsp_Data, O_Rsp_Flags, O_Idle
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible requester after
// the last granted one.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_elig [N]   : eligible requesters
//   o_gnt  [N]   : one-hot grant (combinational)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_elig,
  output logic [N-1:0] o_gnt
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_c;
  logic          w_found;
  int            c;

  // Scan ptr+1 .. ptr+N (mod N); the pointer itself is checked last.
  always_comb begin
    o_gnt   = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    c       = 0;
    w_c     = '0;
    for (int off = 1; off <= N; off++) begin
      c = int'(r_ptr) + off;
      if (c >= N) c = c - N;
      w_c = PW'(c);
      if (!w_found && i_elig[w_c]) begin
        w_found      = 1'b1;
        w_idx        = w_c;
        o_gnt[w_c]   = 1'b1;
      end
    end
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge i_clk) begin
    if (i_rst)        r_ptr <= PW'(N - 1);
    else if (w_found) r_ptr <= w_idx;
  end
endmodule

// File: rtl/fpu_issue_arbiter.sv
// Shares one fixed-latency pipelined FPU among NUM_REQ requesters.
//   I_Clk, I_Reset : clock, synchronous active-high reset
//   bus (slave)    : requests/operands in, one-hot grant out, registered FPU
//                    issue out, FPU result/flags in, one-hot response strobe
//                    with broadcast result/flags out, O_Idle
// A grant in cycle T issues in T+1 and responds in T+1+PIPE_LEN. The
// requester id rides a PIPE_LEN-deep tag pipe whose tail lines up with
// I_Fpu_Result. Each requester may have at most MAX_OUTSTANDING ops in flight.
module fpu_issue_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 32,
  parameter int OP_WIDTH        = 4,
  parameter int PIPE_LEN        = 3,
  parameter int MAX_OUTSTANDING = 2
) (
  input logic               I_Clk,
  input logic               I_Reset,
  fpu_issue_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]          w_elig, w_gnt, w_rsp;
  logic [NUM_REQ-1:0][CW-1:0]  r_cnt;
  logic [MAX_REQ-1:0]          w_gnt_ext;
  logic [ID_W-1:0]             w_gnt_id, r_issue_id;
  logic [OP_WIDTH-1:0]         w_op, r_op;
  logic [DATA_WIDTH-1:0]       w_a, w_b, r_a, r_b;
  logic                        r_fpu_valid;
  fpu_tag_t                    r_tag [PIPE_LEN];
  fpu_tag_t                    w_tail;
  logic                        w_tag_busy, w_cnt_zero;

  assign w_tail = r_tag[PIPE_LEN-1];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    // Registered count only: a response this cycle does not unblock a grant.
    assign w_elig[i] = bus.I_Req[i] & ~bus.I_Hold & ~I_Reset &
                       (r_cnt[i] < CW'(MAX_OUTSTANDING));
    // Reset drops whatever result is at the tail this cycle.
    assign w_rsp[i]  = w_tail.valid & (w_tail.id == ID_W'(i)) & ~I_Reset;

    a_no_ovf: assert property (@(posedge I_Clk) disable iff (I_Reset)
      !(w_gnt[i] && !w_rsp[i] && r_cnt[i] == CW'(MAX_OUTSTANDING)));
    a_no_udf: assert property (@(posedge I_Clk) disable iff (I_Reset)
      !(w_rsp[i] && !w_gnt[i] && r_cnt[i] == '0));
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_clk  (I_Clk),
    .i_rst  (I_Reset),
    .i_elig (w_elig),
    .o_gnt  (w_gnt)
  );

  always_comb begin
    w_gnt_ext                = '0;
    w_gnt_ext[NUM_REQ-1:0]   = w_gnt;
  end
  assign w_gnt_id = onehot_to_idx(w_gnt_ext);

  always_comb begin
    w_op = '0;
    w_a  = '0;
    w_b  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_op = bus.I_Op[i*OP_WIDTH +: OP_WIDTH];
        w_a  = bus.I_A[i*DATA_WIDTH +: DATA_WIDTH];
        w_b  = bus.I_B[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue register; payload holds its value when nothing is granted.
  always_ff @(posedge I_Clk) begin
    if (I_Reset) begin
      r_fpu_valid <= 1'b0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_issue_id  <= '0;
    end else begin
      r_fpu_valid <= |w_gnt;
      if (|w_gnt) begin
        r_op       <= w_op;
        r_a        <= w_a;
        r_b        <= w_b;
        r_issue_id <= w_gnt_id;
      end
    end
  end

  always_ff @(posedge I_Clk) begin
    if (I_Reset) begin
      for (int k = 0; k < PIPE_LEN; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0] <= '{valid: r_fpu_valid, id: r_issue_id};
      for (int k = 1; k < PIPE_LEN; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  always_ff @(posedge I_Clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (I_Reset)                  r_cnt[i] <= '0;
      else if (w_gnt[i] & ~w_rsp[i]) r_cnt[i] <= r_cnt[i] + CW'(1);
      else if (~w_gnt[i] & w_rsp[i]) r_cnt[i] <= r_cnt[i] - CW'(1);
    end
  end

  always_comb begin
    w_tag_busy = 1'b0;
    w_cnt_zero = 1'b1;
    for (int k = 0; k < PIPE_LEN; k++) w_tag_busy = w_tag_busy | r_tag[k].valid;
    for (int i = 0; i < NUM_REQ; i++)  w_cnt_zero = w_cnt_zero & (r_cnt[i] == '0);
  end

  assign bus.O_Gnt       = w_gnt;
  assign bus.O_Fpu_Valid = r_fpu_valid;
  assign bus.O_Fpu_Op    = r_op;
  assign bus.O_Fpu_A     = r_a;
  assign bus.O_Fpu_B     = r_b;
  assign bus.O_Rsp_Valid = w_rsp;
  assign bus.O_Rsp_Data  = bus.I_Fpu_Result;
  assign bus.O_Rsp_Flags = bus.I_Fpu_Flags;
  assign bus.O_Idle      = ~r_fpu_valid & ~w_tag_busy & w_cnt_zero;
endmodule

// File: tb/tb_fpu_issue_arbiter.sv
// Directed bench for fpu_issue_arbiter (NUM_REQ=4, PIPE_LEN=3, MAX_OUTSTANDING=2).
// Stimulus pushes expected grants/issues/responses into queues; a negedge
// monitor pops and compares whenever the DUT presents one.
module tb_fpu_issue_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_issue_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32), .OP_WIDTH(4)) bus();

  fpu_issue_arbiter #(
    .NUM_REQ(4), .DATA_WIDTH(32), .OP_WIDTH(4), .PIPE_LEN(3), .MAX_OUTSTANDING(2)
  ) dut (
    .I_Clk   (clk),
    .I_Reset (rst),
    .bus     (bus)
  );

  // FPU model: result/flags are a known function of the cycle number.
  function automatic logic [31:0] fres(int c);
    return 32'hF000_0000 | 32'(c);
  endfunction
  function automatic logic [4:0] fflg(int c);
    return 5'(c) ^ 5'h15;
  endfunction
  assign bus.I_Fpu_Result = fres(cyc);
  assign bus.I_Fpu_Flags  = fflg(cyc);

  typedef struct { int cyc; logic [3:0] v; } gnt_e;
  typedef struct { int cyc; logic [3:0] op; logic [31:0] a; logic [31:0] b; } iss_e;
  typedef struct { int cyc; logic [3:0] v; logic [31:0] d; logic [4:0] f; } rsp_e;
  gnt_e gq[$];
  iss_e iq[$];
  rsp_e rq[$];

  logic [3:0]  opv [4];
  logic [31:0] av  [4];
  logic [31:0] bv  [4];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic bad(string nm, logic [63:0] act);
    n_chk++;
    n_err++;
    $display("FAIL %s at cycle %0d: got %h, expected nothing here", nm, cyc, act);
  endtask

  // Grant to id in cycle c: issue in c+1, response (if not flushed) in c+4.
  task automatic expect_op(int c, int id, bit with_rsp);
    gnt_e g; iss_e s; rsp_e r;
    g.cyc = c;     g.v = 4'(1 << id);
    s.cyc = c + 1; s.op = opv[id]; s.a = av[id]; s.b = bv[id];
    gq.push_back(g);
    iq.push_back(s);
    if (with_rsp) begin
      r.cyc = c + 4; r.v = 4'(1 << id); r.d = fres(c + 4); r.f = fflg(c + 4);
      rq.push_back(r);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (gq.size() > 0 && gq[0].cyc < cyc) begin bad("gnt_missing", 64'(gq[0].v)); gq.delete(0); end
    if (iq.size() > 0 && iq[0].cyc < cyc) begin bad("iss_missing", 64'(iq[0].a));  iq.delete(0); end
    if (rq.size() > 0 && rq[0].cyc < cyc) begin bad("rsp_missing", 64'(rq[0].v)); rq.delete(0); end

    if (bus.O_Gnt != 4'b0) begin
      if (gq.size() > 0 && gq[0].cyc == cyc) begin
        chk("gnt", 64'(bus.O_Gnt), 64'(gq[0].v));
        gq.delete(0);
      end else bad("gnt_unexpected", 64'(bus.O_Gnt));
    end
    if (bus.O_Fpu_Valid) begin
      if (iq.size() > 0 && iq[0].cyc == cyc) begin
        chk("iss_op_a", 64'({bus.O_Fpu_Op, bus.O_Fpu_A}), 64'({iq[0].op, iq[0].a}));
        chk("iss_b", 64'(bus.O_Fpu_B), 64'(iq[0].b));
        iq.delete(0);
      end else bad("iss_unexpected", 64'(bus.O_Fpu_A));
    end
    if (bus.O_Rsp_Valid != 4'b0) begin
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        chk("rsp", 64'({bus.O_Rsp_Valid, bus.O_Rsp_Flags, bus.O_Rsp_Data}),
                   64'({rq[0].v, rq[0].f, rq[0].d}));
        rq.delete(0);
      end else bad("rsp_unexpected", 64'(bus.O_Rsp_Valid));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c0;
    for (int i = 0; i < 4; i++) begin
      opv[i] = 4'(i + 5);
      av[i]  = 32'hA000_0000 + 32'(i);
      bv[i]  = 32'hB000_0000 + 32'(i);
    end
    opv[2] = 4'h1; av[2] = 32'h3F80_0000; bv[2] = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      bus.I_Op[i*4 +: 4]   = opv[i];
      bus.I_A[i*32 +: 32]  = av[i];
      bus.I_B[i*32 +: 32]  = bv[i];
    end
    rst = 1'b1; bus.I_Hold = 1'b0; bus.I_Req = 4'hF;

    // 1. Reset with all requests asserted
    repeat (2) begin
      @(posedge clk); @(negedge clk);
      chk("rst_gnt",      64'(bus.O_Gnt), 64'd0);
      chk("rst_fpu_vld",  64'(bus.O_Fpu_Valid), 64'd0);
      chk("rst_rsp_vld",  64'(bus.O_Rsp_Valid), 64'd0);
      chk("rst_idle",     64'(bus.O_Idle), 64'd1);
      chk("rst_fpu_op_a", 64'({bus.O_Fpu_Op, bus.O_Fpu_A}), 64'd0);
      chk("rst_fpu_b",    64'(bus.O_Fpu_B), 64'd0);
    end

    // 2. Single op from requester 2
    tick(); rst = 1'b0; bus.I_Req = 4'b0100; c0 = cyc;
    expect_op(c0, 2, 1'b1);
    tick(); bus.I_Req = 4'b0;
    repeat (3) tick();
    @(negedge clk); chk("idle_busy", 64'(bus.O_Idle), 64'd0);
    tick();
    @(negedge clk); chk("idle_after_single", 64'(bus.O_Idle), 64'd1);

    // 3. Fairness from a fresh reset
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; bus.I_Req = 4'hF; c0 = cyc;
    for (int k = 0; k < 8; k++) expect_op(c0 + k, k % 4, 1'b1);
    repeat (8) tick();
    bus.I_Req = 4'b0;
    repeat (5) tick();

    // 4. Outstanding cap on requester 1
    bus.I_Req = 4'b0010; c0 = cyc;
    expect_op(c0,      1, 1'b1);
    expect_op(c0 + 1,  1, 1'b1);
    expect_op(c0 + 5,  1, 1'b1);
    expect_op(c0 + 6,  1, 1'b1);
    expect_op(c0 + 10, 1, 1'b1);
    expect_op(c0 + 11, 1, 1'b1);
    repeat (12) tick();
    bus.I_Req = 4'b0;
    repeat (6) tick();

    // 5. Hold after three grants; in-flight ops drain
    bus.I_Req = 4'hF; c0 = cyc;
    expect_op(c0,     2, 1'b1);
    expect_op(c0 + 1, 3, 1'b1);
    expect_op(c0 + 2, 0, 1'b1);
    repeat (3) tick();
    bus.I_Hold = 1'b1;
    @(negedge clk); chk("hold_gnt", 64'(bus.O_Gnt), 64'd0);
    repeat (3) tick();
    @(negedge clk); chk("hold_idle_busy", 64'(bus.O_Idle), 64'd0);
    tick();
    @(negedge clk); chk("hold_idle_drained", 64'(bus.O_Idle), 64'd1);
    tick(); bus.I_Hold = 1'b0; bus.I_Req = 4'b0;

    // 6. Reset while two ops are in flight
    tick(); bus.I_Req = 4'hF; c0 = cyc;
    expect_op(c0,     1, 1'b0);
    expect_op(c0 + 1, 2, 1'b0);
    tick();
    tick(); bus.I_Req = 4'b0;
    tick(); rst = 1'b1; bus.I_Req = 4'hF;
    @(negedge clk); chk("midrst_gnt", 64'(bus.O_Gnt), 64'd0);
    tick(); rst = 1'b0;
    expect_op(c0 + 4, 0, 1'b1);
    @(negedge clk); chk("midrst_idle", 64'(bus.O_Idle), 64'd1);
    tick(); bus.I_Req = 4'b0;
    repeat (6) tick();
    @(negedge clk); chk("final_idle", 64'(bus.O_Idle), 64'd1);

    chk("gnt_q_drained", 64'(gq.size()), 64'd0);
    chk("iss_q_drained", 64'(iq.size()), 64'd0);
    chk("rsp_q_drained", 64'(rq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fpu_issue_arbiter.md
Name: fpu_issue_arbiter

Overview:
Shares one fixed-latency pipelined FPU datapath among N requesters.
- Grants one operation per cycle using round-robin order.
- Registers the granted operation into the FPU.
- Carries the requester ID through a tag pipeline that matches the FPU latency, and routes each result back to its originator.
- Caps in-flight operations per requester, and provides a hold input so the FPU can be drained.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_WIDTH, 32, operand/result width
OP_WIDTH, 4, FPU opcode width
PIPE_LEN, 3, FPU latency in cycles from O_Fpu_Valid to matching I_Fpu_Result (>=1)
MAX_OUTSTANDING, 2, max in-flight ops per requester (>=1)

Ports:
I_Clk  input  1  clock, all logic on rising edge
I_Reset  input  1  synchronous, active-high reset
I_Req  input  NUM_REQ  per-requester request
I_Op  input  NUM_REQ*OP_WIDTH  opcodes, requester i in slice i
I_A  input  NUM_REQ*DATA_WIDTH  operand A per requester
I_B  input  NUM_REQ*DATA_WIDTH  operand B per requester
I_Hold  input  1  block new grants; in-flight ops drain
O_Gnt  output  NUM_REQ  one-hot grant, combinational; op consumed when I_Req[i]&O_Gnt[i]
O_Fpu_Valid  output  1  registered issue strobe to FPU
O_Fpu_Op  output  OP_WIDTH  registered opcode
O_Fpu_A  output  DATA_WIDTH  registered operand A
O_Fpu_B  output  DATA_WIDTH  registered operand B
I_Fpu_Result  input  DATA_WIDTH  FPU result, valid PIPE_LEN cycles after issue
I_Fpu_Flags  input  FLAG_WIDTH  FPU exception flags aligned with result
O_Rsp_Valid  output  NUM_REQ  one-hot response strobe to originating requester
O_Rsp_Data  output  DATA_WIDTH  I_Fpu_Result passthrough, broadcast to all requesters
O_Rsp_Flags  output  FLAG_WIDTH  I_Fpu_Flags passthrough
O_Idle  output  1  no issue pending, tag pipe empty, all counters zero

Behaviour:
Reset:
- I_Reset is sampled on I_Clk only.
- During and after reset: O_Gnt=0, O_Fpu_Valid=0, O_Fpu_Op/A/B=0, O_Rsp_Valid=0, O_Idle=1.
- Reset also sets the RR pointer to NUM_REQ-1 (requester 0 has first priority), clears all counters and clears the tag pipe.

Eligibility:
- Requester i is eligible when I_Req[i] & ~I_Hold & ~I_Reset & Cnt[i] < MAX_OUTSTANDING.
- Cnt[i] is the registered value; a same-cycle decrement does not unblock.

Arbitration:
- Search eligible requesters starting at pointer+1 and wrapping modulo NUM_REQ; grant the first match.
- The pointer updates to the granted index only when a grant occurs.
- At most one grant per cycle. No eligible requester means O_Gnt=0.

Issue:
- On a grant in cycle T, O_Fpu_Valid=1 in cycle T+1, with the granted Op/A/B and ID captured.
- With no grant, O_Fpu_Valid=0 and O_Fpu_Op/A/B hold their last values.

Tag pipe:
- PIPE_LEN-deep shift of {valid, id}; it loads {O_Fpu_Valid, issue id} every cycle.
- The tail entry describes the result present on I_Fpu_Result this cycle.

Response:
- O_Rsp_Valid = tail.valid ? onehot(tail.id) : 0. This is combinational from the tail.
- O_Rsp_Data and O_Rsp_Flags are unconditional passthroughs.
- There is no response backpressure; requesters must accept the result.

Latency:
- Grant in cycle T gives the response in cycle T+1+PIPE_LEN.

Counters:
- Width is clog2(MAX_OUTSTANDING+1).
- Cnt[i] increments on a grant to i and decrements on O_Rsp_Valid[i].
- Both in the same cycle leaves Cnt[i] unchanged.
- Overflow and underflow cannot occur by construction; add assertions for both.

Hold:
- I_Hold suppresses grants only. Issue register, tag pipe and responses continue.

Reset mid-operation:
- All in-flight tags are dropped and their FPU results are ignored (no O_Rsp_Valid).

O_Idle:
- O_Idle = ~O_Fpu_Valid & no valid tag-pipe entry & all Cnt==0.

Decomposition:
- fpu_arb_pkg holds:
  - FLAG_WIDTH=5
  - typedef fpu_tag_t {logic valid; logic [ID_W-1:0] id}
  - function onehot_to_idx
- Sub-module rr_arbiter (NUM_REQ): eligible vector in, one-hot grant out, internal pointer with synchronous active-high reset. It is reused elsewhere in the FPU.

Test Plan:
All scenarios use NUM_REQ=4, PIPE_LEN=3, MAX_OUTSTANDING=2.
1. Reset: I_Reset=1 for 2 cycles with I_Req=4'hF -> O_Gnt=0, O_Fpu_Valid=0, O_Rsp_Valid=0, O_Idle=1 throughout.
2. Single op: I_Req=4'b0100 for 1 cycle in cycle 0 with A=32'h3F800000, B=32'h40000000, Op=1 -> O_Gnt=4'b0100 in cycle 0; O_Fpu_Valid=1 with A/B/Op in cycle 1; O_Rsp_Valid=4'b0100 in cycle 4, O_Rsp_Data=I_Fpu_Result; O_Idle=1 from cycle 5.
3. Fairness: I_Req=4'hF held -> grant order 0,1,2,3,0,1,... one per cycle; no requester exceeds Cnt=2.
4. Outstanding cap: only I_Req[1] held from cycle 0 -> grants in cycles 0 and 1; no grant in cycles 2-4; next grant in cycle 5 (Cnt drops in cycle 4); steady pattern 2 grants per 5 cycles.
5. Hold/drain: after 3 grants, I_Hold=1 with I_Req=4'hF -> O_Gnt=0 immediately; all 3 responses still delivered; O_Idle=1 one cycle after the last O_Rsp_Valid.
6. Reset mid-flight: assert I_Reset one cycle after 2 issues -> no O_Rsp_Valid for either; counters 0; the first post-reset grant goes to requester 0.
